// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with a valid/ready request channel and fixed-latency response pulse
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_len,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic we_q, we_d;
    logic [1:0] len_q, len_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic resp_valid_q, resp_valid_d;
    logic resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem [2**ADDR_W];
    logic accept;
    logic cur_we, cur_err;
    logic [1:0] cur_len;
    logic [ADDR_W+1:0] cur_addr;
    logic [31:0] rd_word, rd_shift, load_data, wlanes;
    logic [3:0] wmask;
    logic commit;
    logic unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
        we_q    <= we_d;
        len_q   <= len_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && accept) begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = (LATENCY == 1) ? RESP : WAIT;
        end else if (state_q == WAIT) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q <= 4'd1) ? RESP : WAIT;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        req_ready  = state_q == IDLE;
        resp_valid = resp_valid_q;
        resp_err   = resp_err_q;
        resp_rdata = resp_rdata_q;
    end

    // With LATENCY=1 the response is formed on the accept edge, so use the live request in IDLE
    always_comb begin
        we_d      = accept ? req_we : we_q;
        len_d     = accept ? req_len : len_q;
        addr_d    = accept ? req_addr[ADDR_W+1:0] : addr_q;
        wdata_d   = accept ? req_wdata : wdata_q;
        cur_we    = (state_q == IDLE) ? req_we : we_q;
        cur_len   = (state_q == IDLE) ? req_len : len_q;
        cur_addr  = (state_q == IDLE) ? req_addr[ADDR_W+1:0] : addr_q;
        cur_err   = (cur_len == 2'd3) || (cur_len == 2'd1 && cur_addr[0]) ||
                    (cur_len == 2'd0 && cur_addr[1:0] != 2'd0);
        rd_word   = mem[cur_addr[ADDR_W+1:2]];
        rd_shift  = rd_word >> {cur_addr[1:0], 3'b000};
        load_data = (cur_len == 2'd0) ? rd_word :
                    (cur_len == 2'd1) ? {16'd0, rd_shift[15:0]} : {24'd0, rd_shift[7:0]};
        resp_valid_d = state_d == RESP;
        resp_err_d   = (state_d == RESP) ? cur_err : resp_err_q;
        resp_rdata_d = (state_d == RESP) ? ((cur_err || cur_we) ? 32'd0 : load_data) : resp_rdata_q;
        wlanes = (len_q == 2'd0) ? wdata_q :
                 (len_q == 2'd1) ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
        wmask  = (len_q == 2'd0) ? 4'hF :
                 (len_q == 2'd1) ? (addr_q[1] ? 4'hC : 4'h3) : (4'b0001 << addr_q[1:0]);
        commit = state_q == RESP && we_q && !resp_err_q && !rst;
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[addr_q[ADDR_W+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus with a queue scoreboard checked by an independent response monitor
module tb_dmem_responder;
    parameter int LAT = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, req_ready, resp_valid, resp_err;
    logic [1:0] req_len = 2'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, resp_rdata;
    logic v1 = 1'b0, we1 = 1'b0, rdy1, rv1, err1;
    logic [1:0] len1 = 2'd0;
    logic [31:0] addr1 = 32'd0, wd1 = 32'd0, rd1;
    int total = 0, bad = 0, cyc = 0, acc = 0;
    logic [32:0] expq[$];
    bit busy = 0, gap_broken = 1;
    logic rst_q = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_len(req_len), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
        .req_len(len1), .req_addr(addr1), .req_wdata(wd1),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Monitor: pops one expectation per response pulse and checks timing and handshake
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_q) busy = 0;
        if (!req_valid || rst) gap_broken = 1;
        if (busy && !resp_valid) chk("ready_low_busy", 32'(req_ready), 32'd0);
        if (resp_valid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 want 0 (cycle %0d)", cyc);
            end else begin
                e = expq.pop_front();
                chk("resp_err", 32'(resp_err), 32'(e[32]));
                chk("resp_rdata", resp_rdata, e[31:0]);
                chk("latency", 32'(cyc - acc), 32'(LAT));
            end
            chk("ready_low_resp", 32'(req_ready), 32'd0);
            busy = 0;
        end
        if (req_valid && req_ready && !rst) begin
            if (!gap_broken) chk("accept_gap", 32'(cyc - acc), 32'(LAT + 1));
            acc = cyc;
            busy = 1;
            gap_broken = 0;
        end
    end

    task automatic req(input bit w, input logic [1:0] l, input logic [31:0] a, input logic [31:0] d,
                       input bit push, input bit e_err, input logic [31:0] e_data);
        int n;
        if (push) expq.push_back({e_err, e_data});
        req_valid = 1'b1;
        req_we    = w;
        req_len   = l;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 40);
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready=0 want 1 (addr %h)", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        req_valid = 1'b0;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got %0d pending want 0", expq.size());
            expq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a1 [3];
        logic [31:0] d1 [3];
        logic [31:0] x1 [3];
        bit w1 [3];
        logic [1:0] l1 [3];
        int n, a, pa;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        // word store then load; requests are issued back to back so valid is held while busy
        req(1, 2'd0, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0);
        req(0, 2'd0, 32'h10, 32'h0, 1, 0, 32'hDEADBEEF);
        req(1, 2'd0, 32'h20, 32'h11223344, 1, 0, 32'h0);
        req(1, 2'd2, 32'h22, 32'h000000AA, 1, 0, 32'h0);
        req(1, 2'd1, 32'h20, 32'h0000BBCC, 1, 0, 32'h0);
        req(0, 2'd0, 32'h20, 32'h0, 1, 0, 32'h11AABBCC);
        req(0, 2'd2, 32'h23, 32'h0, 1, 0, 32'h00000011);
        req(0, 2'd1, 32'h22, 32'h0, 1, 0, 32'h000011AA);
        req(0, 2'd2, 32'h20, 32'h0, 1, 0, 32'h000000CC);
        req(0, 2'd1, 32'h20, 32'h0, 1, 0, 32'h0000BBCC);
        drain();
        req(1, 2'd0, 32'h30, 32'h01020304, 1, 0, 32'h0);
        req(1, 2'd1, 32'h31, 32'h0000FFFF, 1, 1, 32'h0);
        req(0, 2'd0, 32'h32, 32'h0, 1, 1, 32'h0);
        req(1, 2'd3, 32'h30, 32'hFFFFFFFF, 1, 1, 32'h0);
        req(0, 2'd0, 32'h30, 32'h0, 1, 0, 32'h01020304);
        req(1, 2'd0, 32'h1004, 32'h5A5A5A5A, 1, 0, 32'h0);
        req(0, 2'd0, 32'h0004, 32'h0, 1, 0, 32'h5A5A5A5A);
        drain();
        // reset while a store is in flight aborts it
        req(1, 2'd0, 32'h40, 32'h0, 1, 0, 32'h0);
        drain();
        req(1, 2'd0, 32'h40, 32'hCAFEF00D, LAT == 1, 0, 32'h0);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        req(0, 2'd0, 32'h40, 32'h0, 1, 0, 32'h0);
        drain();
        // LATENCY=1 instance: held valid, one accept every two cycles
        w1 = '{1'b1, 1'b0, 1'b0};
        l1 = '{2'd0, 2'd0, 2'd2};
        a1 = '{32'h8, 32'h8, 32'h9};
        d1 = '{32'h12345678, 32'h0, 32'h0};
        x1 = '{32'h0, 32'h12345678, 32'h00000056};
        pa = 0;
        v1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            we1 = w1[i];
            len1 = l1[i];
            addr1 = a1[i];
            wd1 = d1[i];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rdy1 && n < 10);
            a = cyc;
            chk("lat1_ready", 32'(rdy1), 32'd1);
            if (i > 0) chk("lat1_gap", 32'(a - pa), 32'd2);
            pa = a;
            @(negedge clk);
            chk("lat1_valid", 32'(rv1), 32'd1);
            chk("lat1_rdata", rd1, x1[i]);
            chk("lat1_ready_resp", 32'(rdy1), 32'd0);
        end
        v1 = 1'b0;
        @(negedge clk);
        chk("lat1_single_pulse", 32'(rv1), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
